// File: rtl/reg_file_sb.sv
// Register file with a per-register busy scoreboard.
// Read ports are combinational with optional same-cycle writeback forwarding.
// Issue reserves a destination register and writeback releases it.
// pendingCount reports how many registers are currently reserved.
module reg_file_sb #(
  parameter int XLEN   = 32,
  parameter int NREGS  = 32,
  parameter int NREAD  = 2,
  parameter int BYPASS = 1,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREAD*AW-1:0]   readAddr,
  output logic [NREAD*XLEN-1:0] readData,
  output logic [NREAD-1:0]      readReady,
  input  logic                  writeEnC,
  input  logic [AW-1:0]         writeC,
  input  logic [XLEN-1:0]       writeDataC,
  input  logic                  issueEn,
  input  logic [AW-1:0]         issueRd,
  output logic                  issueOk,
  output logic [AW:0]           pendingCount
);

  logic [XLEN-1:0]  regs [NREGS];
  logic [NREGS-1:0] busy;
  logic [NREGS-1:0] busyNext;
  logic             writeLive;

  // Register 0 is hardwired to zero, so writes that target it are dropped.
  assign writeLive = writeEnC && (writeC != '0);

  // A busy register may still be issued if the writeback on this edge releases it.
  assign issueOk = issueEn && ((issueRd == '0) || !busy[issueRd] ||
                               (writeEnC && (writeC == issueRd)));

  // Data array update: writeback lands on the rising edge regardless of busy.
  // NOTE: the array is cleared on reset because every register must read 0
  // after reset. This forces the array into flops; it cannot map to a RAM.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (writeLive) begin
      // NOTE: state is updated with non-blocking assignments so every flop
      // samples its inputs from before the edge, whatever the statement order.
      regs[writeC] <= writeDataC;
    end
  end

  // Next busy vector: clear on writeback, then set on issue, so set wins a tie.
  always_comb begin
    // NOTE: assigning the default first means every path drives busyNext,
    // which avoids an inferred latch.
    busyNext = busy;
    if (writeLive) busyNext[writeC] = 1'b0;
    if (issueOk && (issueRd != '0)) busyNext[issueRd] = 1'b1;
    busyNext[0] = 1'b0;
  end

  // Busy scoreboard register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) busy <= '0;
    else        busy <= busyNext;
  end

  // pendingCount is the popcount of busy. It is exact by construction and cannot wrap.
  always_comb begin
    pendingCount = '0;
    for (int i = 0; i < NREGS; i++) pendingCount = pendingCount + (AW+1)'(busy[i]);
  end

  // Read ports: addressed register, or forwarded writeback data when bypass is enabled.
  always_comb begin
    logic [AW-1:0] addr;
    readData  = '0;
    readReady = '0;
    addr      = '0;
    for (int p = 0; p < NREAD; p++) begin
      addr = readAddr[p*AW +: AW];
      readData[p*XLEN +: XLEN] = (addr == '0) ? '0 : regs[addr];
      readReady[p]             = !busy[addr];
      if ((BYPASS != 0) && writeLive && (writeC == addr)) begin
        readData[p*XLEN +: XLEN] = writeDataC;
        readReady[p]             = 1'b1;
      end
    end
  end

endmodule
